// File: rtl/seg_scan_mux_if.sv
// Upstream write/commit bus for the seven-segment scan driver.
// The pattern generator is the master; seg_scan_mux is the slave.
interface seg_scan_mux_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_pending;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output commit,
        input  commit_pending
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output commit_pending
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Eight-digit seven-segment scan driver with shadow/active buffers.
// Shadow swaps to active only on the frame boundary; each slot starts blanked.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_mux_if.slave     bus,
    output logic              frame_start,
    output logic [7:0]        seg,
    output logic [7:0]        digit
);

    localparam int             CW    = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK = CW'(BLANK_CYCLES);
    localparam logic [7:0]     OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shadow [8];
    logic [7:0]    r_active [8];
    logic          r_pending;
    logic          r_frame_start;
    logic [7:0]    r_seg;
    logic [7:0]    r_digit;

    logic          w_slot_wrap;
    logic          w_frame_wrap;
    logic          w_swap;
    logic [CW-1:0] w_cnt_n;
    logic [2:0]    w_idx_n;
    logic [7:0]    w_pat;
    logic          w_blank;
    logic [7:0]    w_dig_oh;
    logic [7:0]    w_seg_n;
    logic [7:0]    w_dig_n;
    logic          w_pend_n;

    // Next-state scan position and the output values that go with it.
    always_comb begin
        w_slot_wrap  = (r_cnt == LAST);
        w_frame_wrap = w_slot_wrap && (r_idx == 3'd7);
        w_swap       = w_frame_wrap && r_pending;
        w_cnt_n      = w_slot_wrap ? '0 : r_cnt + CW'(1);
        w_idx_n      = w_slot_wrap ? r_idx + 3'd1 : r_idx;
        // On a swap edge the new active contents are the old shadow.
        w_pat        = w_swap ? r_shadow[w_idx_n] : r_active[w_idx_n];
        w_blank      = (BLANK_CYCLES > 0) && (w_cnt_n < BLANK);
        w_dig_oh     = 8'h01 << w_idx_n;
        w_seg_n      = OFF;
        w_dig_n      = OFF;
        if (!w_blank) begin
            w_seg_n = (ACTIVE_LOW != 0) ? ~w_pat : w_pat;
            w_dig_n = (ACTIVE_LOW != 0) ? ~w_dig_oh : w_dig_oh;
        end
        // A commit on the boundary edge re-arms for the following frame.
        w_pend_n     = w_frame_wrap ? bus.commit : (r_pending | bus.commit);
    end

    // Shadow takes writes; active reloads from pre-edge shadow on a swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 8'h00;
                r_active[i] <= 8'h00;
            end
        end else begin
            if (w_swap) begin
                for (int i = 0; i < 8; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (bus.wr_en) begin
                r_shadow[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Scan counters, commit tracking and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_seg         <= OFF;
            r_digit       <= OFF;
        end else begin
            r_cnt         <= w_cnt_n;
            r_idx         <= w_idx_n;
            r_pending     <= w_pend_n;
            r_frame_start <= w_frame_wrap;
            r_seg         <= w_seg_n;
            r_digit       <= w_dig_n;
        end
    end

    assign bus.commit_pending = r_pending;
    assign frame_start        = r_frame_start;
    assign seg                = r_seg;
    assign digit              = r_digit;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with an 8-cycle slot and 2-cycle blank.
// Cycle index cyc counts edges since reset release; one frame is 64 cycles.
module tb_seg_scan_mux;

    localparam int RD = 8;
    localparam int BL = 2;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic [7:0] seg;
    logic [7:0] digit;

    seg_scan_mux_if bus ();

    seg_scan_mux #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .frame_start (frame_start),
        .seg         (seg),
        .digit       (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [7:0] dig;
        logic       fs;
    } vec_t;

    int         n_run;
    int         n_fail;
    int         cyc;
    logic [7:0] m_shadow [8];
    logic [7:0] m_active [8];
    logic       m_pend;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = 8'h00;
        end
        m_pend = 1'b0;
        cyc    = 0;
    endtask

    task automatic check_model();
        int         c;
        int         x;
        logic [7:0] one;
        logic [7:0] e_dig;
        logic [7:0] e_seg;
        c     = cyc % RD;
        x     = (cyc / RD) % 8;
        one   = 8'h01;
        e_dig = 8'hFF;
        e_seg = 8'hFF;
        if (c >= BL) begin
            e_dig = ~(one << x);
            e_seg = ~m_active[x];
        end
        chk("digit", digit, e_dig);
        chk("seg", seg, e_seg);
        chk("frame_start", {7'd0, frame_start}, {7'd0, (c == 0 && x == 0)});
        chk("pending", {7'd0, bus.commit_pending}, {7'd0, m_pend});
    endtask

    task automatic tick();
        logic       b_rst;
        logic       b_we;
        logic [2:0] b_wa;
        logic [7:0] b_wd;
        logic       b_cm;
        b_rst = rst;
        b_we  = bus.wr_en;
        b_wa  = bus.wr_addr;
        b_wd  = bus.wr_data;
        b_cm  = bus.commit;
        @(posedge clk);
        #1;
        if (b_rst) begin
            model_reset();
        end else begin
            cyc++;
            if (cyc % (8 * RD) == 0) begin
                if (m_pend) begin
                    for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                end
                m_pend = b_cm;
            end else begin
                m_pend = m_pend | b_cm;
            end
            if (b_we) m_shadow[b_wa] = b_wd;
            check_model();
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    vec_t vt [14];
    int   pulses;

    initial begin
        vt[0]  = '{1,  8'hFF, 8'hFF, 1'b0};
        vt[1]  = '{2,  8'hFF, 8'hFE, 1'b0};
        vt[2]  = '{7,  8'hFF, 8'hFE, 1'b0};
        vt[3]  = '{8,  8'hFF, 8'hFF, 1'b0};
        vt[4]  = '{9,  8'hFF, 8'hFF, 1'b0};
        vt[5]  = '{10, 8'hFF, 8'hFD, 1'b0};
        vt[6]  = '{18, 8'hFF, 8'hFB, 1'b0};
        vt[7]  = '{26, 8'hFF, 8'hF7, 1'b0};
        vt[8]  = '{34, 8'hFF, 8'hEF, 1'b0};
        vt[9]  = '{42, 8'hFF, 8'hDF, 1'b0};
        vt[10] = '{50, 8'hFF, 8'hBF, 1'b0};
        vt[11] = '{58, 8'hFF, 8'h7F, 1'b0};
        vt[12] = '{64, 8'hFF, 8'hFF, 1'b1};
        vt[13] = '{66, 8'hFF, 8'hFE, 1'b0};

        n_run       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 8'h00;
        bus.commit  = 1'b0;
        model_reset();

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_seg", seg, 8'hFF);
            chk("rst_digit", digit, 8'hFF);
            chk("rst_fs", {7'd0, frame_start}, 8'h00);
            chk("rst_pend", {7'd0, bus.commit_pending}, 8'h00);
        end
        rst = 1'b0;

        // Scan order and blank timing from release.
        for (int i = 0; i < 14; i++) begin
            run_to(vt[i].cyc);
            chk("t1_seg", seg, vt[i].seg);
            chk("t1_digit", digit, vt[i].dig);
            chk("t1_fs", {7'd0, frame_start}, {7'd0, vt[i].fs});
        end

        // Write without commit leaves the display alone.
        wr(3'd0, 8'h3F);
        run_to(130);
        chk("t2_seg", seg, 8'hFF);
        chk("t2_digit", digit, 8'hFE);
        run_to(194);
        chk("t2_pend", {7'd0, bus.commit_pending}, 8'h00);

        // Commit mid-frame takes effect at the next boundary.
        wr(3'd0, 8'h3F);
        wr(3'd7, 8'h80);
        run_to(211);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        chk("t3_pend_set", {7'd0, bus.commit_pending}, 8'h01);
        run_to(255);
        chk("t3_pend_hold", {7'd0, bus.commit_pending}, 8'h01);
        tick();
        chk("t3_fs", {7'd0, frame_start}, 8'h01);
        chk("t3_pend_clr", {7'd0, bus.commit_pending}, 8'h00);
        run_to(258);
        chk("t3_seg0", seg, 8'hC0);
        chk("t3_dig0", digit, 8'hFE);
        run_to(314);
        chk("t3_seg7", seg, 8'h7F);
        chk("t3_dig7", digit, 8'h7F);

        // Commit and write on the boundary cycle itself.
        run_to(299);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        wr(3'd2, 8'h5B);
        run_to(319);
        bus.commit  = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd1;
        bus.wr_data = 8'h06;
        tick();
        bus.commit  = 1'b0;
        bus.wr_en   = 1'b0;
        chk("t4_pend", {7'd0, bus.commit_pending}, 8'h01);
        chk("t4_fs", {7'd0, frame_start}, 8'h01);
        run_to(330);
        chk("t4_seg1_old", seg, 8'hFF);
        chk("t4_dig1", digit, 8'hFD);
        run_to(338);
        chk("t4_seg2", seg, 8'hA4);
        run_to(384);
        chk("t4_pend_clr", {7'd0, bus.commit_pending}, 8'h00);
        run_to(394);
        chk("t4_seg1_new", seg, 8'hF9);
        chk("t4_dig1b", digit, 8'hFD);

        // frame_start pulses once per 64 cycles.
        pulses = 0;
        while (cyc < 640) begin
            tick();
            if (frame_start === 1'b1) pulses++;
        end
        chk("t5_pulses", 8'(pulses), 8'd4);

        // Reset mid-scan with a commit pending.
        run_to(649);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        run_to(658);
        chk("t6_dig_pre", digit, 8'hFB);
        rst = 1'b1;
        tick();
        chk("t6_seg", seg, 8'hFF);
        chk("t6_digit", digit, 8'hFF);
        chk("t6_pend", {7'd0, bus.commit_pending}, 8'h00);
        rst = 1'b0;
        run_to(5);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        run_to(66);
        chk("t6_seg0", seg, 8'hFF);
        chk("t6_dig0", digit, 8'hFE);
        run_to(122);
        chk("t6_seg7", seg, 8'hFF);
        chk("t6_dig7", digit, 8'h7F);
        run_to(130);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Time-multiplexed 8-digit seven-segment display driver. It sits directly downstream of the pattern generators, e.g. the rotating-square circuit. Upstream logic writes per-digit segment patterns into a shadow buffer and commits them. The block swaps shadow to active only at a frame boundary, so the display never tears, then scans the digits one-hot with an anti-ghosting blank interval before each digit.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot; legal range 2 or more.
BLANK_CYCLES, 1000, cycles at the start of each slot with all digits off; legal range 0 to REFRESH_DIV-1.
ACTIVE_LOW, 1, 1 = seg and digit outputs are driven active-low (board default); 0 = active-high.

Ports:
clk  in  1  system clock, rising edge; the block's only clock.
rst  in  1  synchronous reset, active-high.
wr_en  in  1  write strobe into the shadow buffer.
wr_addr  in  3  digit index to write (0 = rightmost digit).
wr_data  in  8  segment pattern, active-high (bit0 = a … bit6 = g, bit7 = dp).
commit  in  1  one-cycle pulse requesting a shadow-to-active swap at the next frame boundary.
commit_pending  out  1  a commit is latched and not yet applied.
frame_start  out  1  one-cycle pulse in the first cycle of each slot 0.
seg  out  8  segment drive, polarity per ACTIVE_LOW.
digit  out  8  digit enables, one-hot or none, polarity per ACTIVE_LOW.

Behaviour:
- Interface: single clock domain on clk; rst is synchronous and active-high. All outputs are registered.
- Reset (rst high at a clock edge):
  - slot counter cnt = 0, slot index idx = 0.
  - Shadow and active buffers are all 8'h00.
  - commit_pending = 0, frame_start = 0.
  - seg and digit are off: 8'hFF if ACTIVE_LOW, else 8'h00.
- Reset mid-scan blanks the outputs at the next edge and discards buffers and any pending commit.
- Slot counter:
  - cnt increments by 1 every cycle.
  - When cnt = REFRESH_DIV-1, it wraps to 0 and idx advances modulo 8 (7 wraps to 0).
- Phases within a slot:
  - BLANK while cnt < BLANK_CYCLES: seg and digit off.
  - DRIVE while cnt >= BLANK_CYCLES: digit bit idx on, all other digit bits off; seg = active[idx], inverted when ACTIVE_LOW.
  - Output registers are loaded from next-state values, so outputs track cnt and idx in the same cycle.
  - BLANK_CYCLES = 0 means no blank phase.
- Timing from reset release:
  - First edge after rst falls gives cnt = 1.
  - Digit 0 first drives once cnt reaches BLANK_CYCLES.
  - One slot is REFRESH_DIV cycles; one frame is 8 × REFRESH_DIV cycles.
- Writes: wr_en at an edge stores wr_data into shadow[wr_addr]. A later write to the same address overwrites the earlier one. Writes never touch the active buffer directly.
- Commit:
  - commit sets commit_pending.
  - A repeated commit while pending has no extra effect.
- Frame boundary (the edge where idx wraps from 7 to 0):
  - If commit_pending = 1: active <= shadow, using the pre-edge shadow contents. A write in that same cycle lands in shadow only and shows after the next commit.
  - commit_pending is cleared, unless commit is asserted in that same cycle; then it stays 1 for the following frame.
  - frame_start = 1 for exactly one cycle: the first cycle of slot 0. It also pulses on each later boundary, including without a commit.
- No backpressure: wr_en and commit are accepted every cycle. There is no busy signal.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1, so one frame = 64 cycles.
1. Reset: hold rst 3 cycles, then release -> seg=FF and digit=FF during reset. digit=FF when cnt=1, digit=FE (seg=FF) when cnt=2..7, digit=FF for 2 cycles, then FD. Full frame order FE,FD,FB,…,7F.
2. Write addr0=3F with no commit -> display unchanged for 2 full frames (seg=FF whenever digit=FE), commit_pending=0.
3. Write addr0=3F and addr7=80, then pulse commit mid-frame -> commit_pending=1 until the boundary. From the next frame: seg=C0 when digit=FE, seg=7F when digit=7F. commit_pending=0 and frame_start pulses in that first cycle.
4. On the boundary cycle, assert commit plus write addr1=06 -> swap excludes 06. commit_pending stays 1. At the next boundary seg=F9 when digit=FD.
5. frame_start period -> exactly one pulse every 64 cycles across 4 frames, coincident with idx=0, cnt=0.
6. rst asserted while digit=FB -> next edge gives seg=FF, digit=FF, commit_pending=0. After release, all digits show FF, i.e. buffers cleared.
